// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/accumulator.
// Mode encodings, the stage-count ceiling and the result-width rule live here.
package pipe_adder_pkg;

  localparam logic MODE_ADD   = 1'b0;
  localparam logic MODE_ACC   = 1'b1;
  localparam int   STAGES_MAX = 4;

  // Result carries one extra bit for the carry out of the operand width.
  function automatic int sum_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/pipe_adder_acc_stage_reg.sv
// Delay stage for the adder pipeline: a {valid,data} register that advances on en.
// Data only loads with a valid beat so bubbles leave the last result in place.
module pipe_stage_reg #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          prev_valid,
  input  logic [DW-1:0] prev_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/pipe_adder_acc.sv
// Pipelined WIDTH-bit adder / accumulator with valid/ready on both sides,
// a sticky accumulate-overflow flag and an accepted-beat counter.
module pipe_adder_acc
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int SW = sum_w(WIDTH);

  logic          adv;
  logic          accept;
  logic          acc_beat;
  logic [SW-1:0] acc_reg;
  logic [SW-1:0] acc_base;
  logic [SW:0]   acc_full;
  logic [SW-1:0] r1;
  logic          ovf_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic          s1_valid_reg;
  logic [SW-1:0] s1_data_reg;

  logic          stage_valid [STAGES];
  logic [SW-1:0] stage_data  [STAGES];

  assign out_valid = stage_valid[STAGES-1];
  assign sum       = stage_data[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign ovf       = ovf_reg;
  assign txn_cnt   = cnt_reg;

  always_comb begin
    accept   = in_valid && adv;
    acc_beat = accept && (mode == MODE_ACC);
    // A clear in the same cycle as an accumulate beat makes that beat start from zero.
    acc_base = acc_clr ? '0 : acc_reg;
    acc_full = {1'b0, acc_base} + {2'b00, a};
    if (mode == MODE_ACC) begin
      r1 = acc_full[SW-1:0];
    end else begin
      r1 = {1'b0, a} + {1'b0, b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      if (acc_beat) begin
        acc_reg <= r1;
      end else if (acc_clr) begin
        acc_reg <= '0;
      end
      ovf_reg <= acc_clr ? 1'b0 : (ovf_reg | (acc_beat & acc_full[SW]));
      if (accept) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else if (adv) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_data_reg <= r1;
      end
    end
  end

  assign stage_valid[0] = s1_valid_reg;
  assign stage_data[0]  = s1_data_reg;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      pipe_stage_reg #(.DW(SW)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (adv),
        .prev_valid (stage_valid[gi-1]),
        .prev_data  (stage_data[gi-1]),
        .valid      (stage_valid[gi]),
        .data       (stage_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pipe_adder_acc.sv
// Bench for pipe_adder_acc: directed scenarios plus random traffic scored
// against an arithmetic reference model; also exercises a WIDTH=16/STAGES=4 build.
module tb_pipe_adder_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, mode, acc_clr, out_valid, out_ready, ovf;
  logic [7:0]  a, b;
  logic [8:0]  sum;
  logic [15:0] txn_cnt;

  logic        w_in_valid, w_in_ready, w_mode, w_acc_clr, w_out_valid, w_out_ready, w_ovf;
  logic [15:0] w_a, w_b;
  logic [16:0] w_sum;
  logic [15:0] w_txn_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         m_acc;
  bit         m_ovf;
  int         m_cnt;
  logic [8:0] m_last;

  pipe_adder_acc #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf), .txn_cnt(txn_cnt)
  );

  pipe_adder_acc #(.WIDTH(16), .STAGES(4), .CNT_W(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .mode(w_mode), .acc_clr(w_acc_clr), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .sum(w_sum), .ovf(w_ovf), .txn_cnt(w_txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_acc  = 0;
    m_ovf  = 0;
    m_cnt  = 0;
    m_last = '0;
  endtask

  // One clock cycle: inputs already driven at the negedge; returns to the next negedge.
  task automatic cycle(output bit accepted);
    bit acc_now;
    bit xfer;
    int full;
    #1;
    checks++;
    if (in_ready !== (!out_valid || out_ready)) begin
      errors++;
      $display("FAIL in_ready: got %b want %b", in_ready, !out_valid || out_ready);
    end
    acc_now = in_valid && in_ready;
    xfer    = out_valid && out_ready;
    checks++;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sum_spurious: got out_valid=1 sum=%h want no result pending", sum);
      end else begin
        if (sum !== exp_q[0]) begin
          errors++;
          $display("FAIL sum: got %h want %h", sum, exp_q[0]);
        end
        m_last = exp_q[0];
        if (xfer) void'(exp_q.pop_front());
      end
    end else if (sum !== m_last) begin
      errors++;
      $display("FAIL sum_hold: got %h want %h while out_valid=0", sum, m_last);
    end
    if (acc_clr) begin
      m_acc = 0;
      m_ovf = 0;
    end
    if (acc_now) begin
      m_cnt++;
      if (mode) begin
        full = m_acc + int'(a);
        if (full >= 512) m_ovf = 1;
        m_acc = full % 512;
        exp_q.push_back(9'(m_acc));
      end else begin
        exp_q.push_back(9'(int'(a) + int'(b)));
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ovf !== m_ovf) begin
      errors++;
      $display("FAIL ovf: got %b want %b", ovf, m_ovf);
    end
    checks++;
    if (txn_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL txn_cnt: got %0d want %0d", txn_cnt, 16'(m_cnt));
    end
    accepted = acc_now;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 0;
    out_ready = 1;
    acc_clr   = 0;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || out_valid); i++) cycle(acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding want 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (out_valid !== 1'b0 || sum !== 9'h0 || ovf !== 1'b0 || txn_cnt !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got out_valid=%b sum=%h ovf=%b txn_cnt=%0d in_ready=%b want 0 000 0 0 1",
               tag, out_valid, sum, ovf, txn_cnt, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 0; a = 0; b = 0; mode = 0; acc_clr = 0; out_ready = 1;
    w_in_valid = 0; w_a = 0; w_b = 0; w_mode = 0; w_acc_clr = 0; w_out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_basic_add();
    bit acc;
    out_ready = 1; mode = 0; in_valid = 1;
    a = 8'hFF; b = 8'h01;
    cycle(acc);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: got out_valid=%b want 0", out_valid);
    end
    a = 8'h10; b = 8'h20;
    cycle(acc);
    checks++;
    if (out_valid !== 1'b1 || sum !== 9'h100) begin
      errors++;
      $display("FAIL add_latency: got out_valid=%b sum=%h want 1 100", out_valid, sum);
    end
    drain();
    checks++;
    if (txn_cnt !== 16'd2) begin
      errors++;
      $display("FAIL add_txn_cnt: got %0d want 2", txn_cnt);
    end
  endtask

  task automatic test_accumulate();
    bit acc;
    out_ready = 1; mode = 1; in_valid = 1; a = 8'h80; b = 8'h33;
    for (int i = 0; i < 5; i++) cycle(acc);
    drain();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL acc_ovf_sticky: got %b want 1", ovf);
    end
  endtask

  task automatic test_acc_clr();
    bit acc;
    out_ready = 1; mode = 1; in_valid = 1; acc_clr = 1; a = 8'h05; b = 8'hAA;
    cycle(acc);
    acc_clr = 0;
    drain();
    checks++;
    if (ovf !== 1'b0 || m_last !== 9'h005) begin
      errors++;
      $display("FAIL acc_clr: got ovf=%b last_sum=%h want 0 005", ovf, m_last);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int idx = 1;
    out_ready = 0; mode = 0; b = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (idx <= 4); a = 8'(idx);
      cycle(acc);
      if (acc) idx++;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 9'h001 || idx != 3) begin
      errors++;
      $display("FAIL backpressure_stall: got in_ready=%b out_valid=%b sum=%h accepted=%0d want 0 1 001 2",
               in_ready, out_valid, sum, idx - 1);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (idx <= 4); a = 8'(idx);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_stream: got out_valid=%b want 1 at drain cycle %0d", out_valid, i);
      end
      cycle(acc);
      if (acc) idx++;
    end
    drain();
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      mode      = $urandom_range(1);
      a         = 8'($urandom);
      b         = 8'($urandom);
      acc_clr   = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      cycle(acc);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    bit acc;
    out_ready = 1; mode = 0; in_valid = 1;
    a = 8'h11; b = 8'h22;
    cycle(acc);
    a = 8'h33; b = 8'h44;
    cycle(acc);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_reset_values("reset_midstream");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    in_valid = 1; mode = 0; a = 8'd3; b = 8'd4;
    cycle(acc);
    drain();
    checks++;
    if (m_last !== 9'h007 || txn_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_restart: got last_sum=%h txn_cnt=%0d want 007 1", m_last, txn_cnt);
    end
  endtask

  task automatic test_wide();
    int nxt = 1;
    int base;
    w_out_ready = 1; w_in_valid = 1; w_mode = 0; w_a = 16'hFFFF; w_b = 16'hFFFF;
    #1;
    checks++;
    if (w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wide_in_ready: got %b want 1", w_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 0;
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (w_out_valid !== (e == 3)) begin
        errors++;
        $display("FAIL wide_latency: got out_valid=%b want %b at edge +%0d", w_out_valid, e == 3, e);
      end
      if (e < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++;
    if (w_sum !== 17'h1FFFE) begin
      errors++;
      $display("FAIL wide_sum: got %h want 1fffe", w_sum);
    end
    base = int'(w_txn_cnt);
    checks++;
    if (base != 1) begin
      errors++;
      $display("FAIL wide_txn_cnt: got %0d want 1", base);
    end
    w_mode = 1; w_a = 16'h0001; w_b = 16'hBEEF;
    for (int k = 1; k <= 13; k++) begin
      w_in_valid = (k <= 10);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (w_txn_cnt !== 16'(base + (k <= 10 ? k : 10))) begin
        errors++;
        $display("FAIL wide_txn_step: got %0d want %0d", w_txn_cnt, base + (k <= 10 ? k : 10));
      end
      if (w_out_valid === 1'b1) begin
        checks++;
        if (w_sum !== 17'(nxt)) begin
          errors++;
          $display("FAIL wide_acc_sum: got %h want %h", w_sum, 17'(nxt));
        end
        nxt++;
      end
    end
    w_in_valid = 0;
    checks++;
    if (nxt != 11) begin
      errors++;
      $display("FAIL wide_acc_stream: got %0d results want 10", nxt - 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_accumulate();
    test_acc_clr();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
